// File: rtl/tetris_pkg.sv
// Shared board geometry, cell type and row server FSM states.
// Address helper keeps row*W+col arithmetic at 8 bits.
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  typedef logic [15:0] cell_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PUBLISH,
    CLEAR
  } state_t;

  function automatic logic [7:0] cell_addr(
    input logic [7:0] row,
    input logic [7:0] col,
    input logic [7:0] w
  );
    return row * w + col;
  endfunction

endpackage

// File: rtl/board_ram.sv
// Single-port board cell store, one access per cycle.
// Synchronous read; contents survive reset.
module board_ram
  import tetris_pkg::*;
#(
  parameter int DEPTH = BOARD_W * BOARD_H
) (
  input  logic        Clk,
  input  logic        en,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);

  cell_t mem [DEPTH];

  always_ff @(posedge Clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end

endmodule

// File: rtl/board_row_server.sv
// Board row server: fetches a board row into a shadow buffer,
// then publishes it whole; game writes win the memory port.
module board_row_server
  import tetris_pkg::cell_t, tetris_pkg::state_t,
         tetris_pkg::cell_addr,
         tetris_pkg::IDLE, tetris_pkg::FETCH,
         tetris_pkg::PUBLISH, tetris_pkg::CLEAR;
#(
  parameter int BOARD_W = tetris_pkg::BOARD_W,
  parameter int BOARD_H = tetris_pkg::BOARD_H
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  LD_Row,
  input  logic [7:0]            rowNum,
  output logic [16*BOARD_W-1:0] Row,
  output logic                  rowReady,
  input  logic                  wr_en,
  input  logic [4:0]            wr_row,
  input  logic [3:0]            wr_col,
  input  logic [15:0]           wr_data,
  input  logic                  clr,
  output logic                  busy
);

  localparam int CW = $clog2(BOARD_W + 1);
  localparam int IW = $clog2(BOARD_W);
  localparam logic [CW-1:0] W_C = CW'(BOARD_W);
  localparam logic [IW-1:0] I_LAST = IW'(BOARD_W - 1);
  localparam logic [7:0] W8 = 8'(BOARD_W);
  localparam logic [7:0] H8 = 8'(BOARD_H);
  localparam logic [7:0] C_LAST = 8'(BOARD_W * BOARD_H - 1);

  state_t        state;
  logic          ld_prev;
  logic          rise;
  logic          pend_vld;
  logic [7:0]    pend_row;
  logic [7:0]    cur_row;
  logic [CW-1:0] rd_col;
  logic [IW-1:0] rd_idx;
  logic          rd_vld;
  logic [7:0]    clr_cnt;
  cell_t         shadow [BOARD_W];
  logic          wr_ok;
  logic          oob;
  logic          issue;
  logic          ram_en;
  logic          ram_we;
  logic [7:0]    ram_addr;
  cell_t         ram_wd;
  cell_t         ram_q;

  assign rise  = LD_Row & ~ld_prev;
  assign oob   = cur_row >= H8;
  assign wr_ok = wr_en && (8'(wr_row) < H8)
                       && (8'(wr_col) < W8);
  assign issue = (state == FETCH) && !wr_ok
                 && (rd_col < W_C);
  assign busy  = state != IDLE;

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = cell_addr(cur_row, 8'(rd_col), W8);
    ram_wd   = '0;
    if (state == CLEAR) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = clr_cnt;
    end else if (wr_ok) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = cell_addr(8'(wr_row), 8'(wr_col), W8);
      ram_wd   = wr_data;
    end else if (issue && !oob) begin
      ram_en   = 1'b1;
    end
  end

  board_ram #(
    .DEPTH(BOARD_W * BOARD_H)
  ) u_ram (
    .Clk   (Clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wd),
    .rdata (ram_q)
  );

  // Out-of-range rows still walk the columns so latency is unchanged.
  always_ff @(posedge Clk)
    if (state == FETCH && !clr && rd_vld)
      shadow[rd_idx] <= oob ? '0 : ram_q;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ld_prev  <= 1'b0;
      pend_vld <= 1'b0;
      pend_row <= '0;
      cur_row  <= '0;
      rd_col   <= '0;
      rd_idx   <= '0;
      rd_vld   <= 1'b0;
      clr_cnt  <= '0;
      Row      <= '0;
      rowReady <= 1'b0;
    end else begin
      ld_prev  <= LD_Row;
      rowReady <= 1'b0;
      if (rise && state != IDLE) begin
        pend_vld <= 1'b1;
        pend_row <= rowNum;
      end
      unique case (state)
        IDLE: begin
          if (clr) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            if (rise) begin
              pend_vld <= 1'b1;
              pend_row <= rowNum;
            end
          end else if (rise || pend_vld) begin
            state    <= FETCH;
            cur_row  <= rise ? rowNum : pend_row;
            pend_vld <= 1'b0;
            rd_col   <= '0;
            rd_vld   <= 1'b0;
          end
        end
        FETCH: begin
          if (clr) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            pend_vld <= 1'b1;
            pend_row <= rise ? rowNum : cur_row;
          end else begin
            rd_vld <= issue;
            if (issue) begin
              rd_idx <= IW'(rd_col);
              rd_col <= rd_col + 1'b1;
            end
            if (rd_vld && rd_idx == I_LAST)
              state <= PUBLISH;
          end
        end
        PUBLISH: begin
          for (int c = 0; c < BOARD_W; c++)
            Row[c*16 +: 16] <= shadow[c];
          rowReady <= 1'b1;
          state    <= IDLE;
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == C_LAST)
            state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_row_server.sv
// Randomized bench for board_row_server against a board-array model.
// Publishes are logged by a monitor and matched to requests.
module tb_board_row_server;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int RW = 16 * W;

  logic          Clk;
  logic          reset;
  logic          LD_Row;
  logic [7:0]    rowNum;
  logic [RW-1:0] Row;
  logic          rowReady;
  logic          wr_en;
  logic [4:0]    wr_row;
  logic [3:0]    wr_col;
  logic [15:0]   wr_data;
  logic          clr;
  logic          busy;

  board_row_server dut (
    .Clk      (Clk),
    .reset    (reset),
    .LD_Row   (LD_Row),
    .rowNum   (rowNum),
    .Row      (Row),
    .rowReady (rowReady),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .clr      (clr),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [15:0]   mm [W*H];
  int            pq_cyc [$];
  logic [RW-1:0] pq_row [$];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk)
    if (rowReady === 1'b1) begin
      pq_cyc.push_back(cyc);
      pq_row.push_back(Row);
    end

  task automatic check(string tag, logic [RW-1:0] obs,
                       logic [RW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge Clk);
  endtask

  function automatic logic [RW-1:0] exp_row(int r);
    logic [RW-1:0] v;
    v = '0;
    if (r < H)
      for (int c = 0; c < W; c++) v[c*16 +: 16] = mm[r*W + c];
    return v;
  endfunction

  task automatic wr(int r, int c, logic [15:0] d);
    wr_en   = 1'b1;
    wr_row  = 5'(r);
    wr_col  = 4'(c);
    wr_data = d;
    if (r < H && c < W) mm[r*W + c] = d;
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic request(int r, int hold, output int rise);
    rowNum = 8'(r);
    LD_Row = 1'b1;
    rise   = cyc + 1;
    step(hold);
    LD_Row = 1'b0;
  endtask

  task automatic wait_pulse(string tag, int n);
    int b = 0;
    while (pq_row.size() < n && b < 800) begin
      step(1);
      b++;
    end
    check({tag, "_timeout"}, RW'(pq_row.size() >= n), RW'(1));
  endtask

  task automatic expect_pulse(string tag, int rise, int lat,
                              logic [RW-1:0] row);
    int pc;
    logic [RW-1:0] pr;
    wait_pulse(tag, 1);
    if (pq_row.size() > 0) begin
      pc = pq_cyc.pop_front();
      pr = pq_row.pop_front();
      if (lat >= 0) check({tag, "_lat"}, RW'(pc - rise), RW'(lat));
      check({tag, "_row"}, pr, row);
    end
  endtask

  task automatic no_more(string tag, int n);
    step(n);
    check({tag, "_extra"}, RW'(pq_row.size()), RW'(0));
    pq_row.delete();
    pq_cyc.delete();
  endtask

  task automatic clear_board();
    int cnt = 0;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    for (int b = 0; b < 1000; b++) begin
      if (!busy) break;
      cnt++;
      step(1);
    end
    check("clear_len", RW'(cnt), RW'(W*H));
    for (int i = 0; i < W*H; i++) mm[i] = '0;
  endtask

  initial begin
    int rs;
    int cnt;
    int r;
    reset   = 1'b1;
    LD_Row  = 1'b0;
    rowNum  = '0;
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_col  = '0;
    wr_data = '0;
    clr     = 1'b0;
    step(3);
    check("rst_row", Row, '0);
    check("rst_ready", RW'(rowReady), RW'(0));
    check("rst_busy", RW'(busy), RW'(0));
    reset = 1'b0;
    step(2);
    check("idle_busy", RW'(busy), RW'(0));
    clear_board();

    // held request: one publish, 12 cycles
    for (int c = 0; c < W; c++) wr(3, c, 16'h0F00 + 16'(c));
    request(3, 4, rs);
    expect_pulse("hold", rs, 12, exp_row(3));
    no_more("hold", 20);

    // writes stall the fetch
    for (int c = 0; c < W; c++) wr(5, c, 16'($urandom));
    request(5, 1, rs);
    step(1);
    wr(8, 1, 16'hA001);
    step(1);
    wr(9, 2, 16'hA002);
    step(1);
    wr(12, 9, 16'hA003);
    expect_pulse("stall", rs, 15, exp_row(5));
    no_more("stall", 10);
    request(8, 1, rs);
    expect_pulse("stall_wr", rs, 12, exp_row(8));

    // out-of-range row
    request(25, 1, rs);
    expect_pulse("oob", rs, 12, '0);
    no_more("oob", 10);

    // pending slot keeps only the newest
    for (int c = 0; c < W; c++) begin
      wr(1, c, 16'($urandom));
      wr(2, c, 16'($urandom));
      wr(4, c, 16'($urandom));
    end
    request(1, 1, rs);
    step(2);
    request(2, 1, r);
    step(2);
    request(4, 1, r);
    wait_pulse("pend", 2);
    expect_pulse("pend1", rs, 12, exp_row(1));
    expect_pulse("pend4", 0, -1, exp_row(4));
    no_more("pend", 30);

    // clear during fetch re-pends the row
    for (int c = 0; c < W; c++) wr(7, c, 16'h7000 | 16'(c + 1));
    request(7, 1, rs);
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    cnt = 0;
    for (int b = 0; b < 800; b++) begin
      if (pq_row.size() != 0) break;
      if (busy) cnt++;
      step(1);
    end
    for (int i = 0; i < W*H; i++) mm[i] = '0;
    check("clr_busy", RW'(cnt >= W*H), RW'(1));
    expect_pulse("clr7", rs, -1, '0);
    no_more("clr7", 10);

    // reset during fetch
    for (int c = 0; c < W; c++) wr(3, c, 16'h0F00 + 16'(c));
    request(6, 1, rs);
    step(4);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("mid_rst_row", Row, '0);
    check("mid_rst_busy", RW'(busy), RW'(0));
    no_more("mid_rst", 20);
    request(3, 4, rs);
    expect_pulse("post_rst", rs, 12, exp_row(3));
    no_more("post_rst", 10);

    // random traffic against the board model
    for (int it = 0; it < 40; it++) begin
      int nw = $urandom_range(1, 8);
      for (int k = 0; k < nw; k++)
        wr($urandom_range(0, 23), $urandom_range(0, 11),
           16'($urandom));
      r = $urandom_range(0, 24);
      request(r, $urandom_range(1, 3), rs);
      expect_pulse($sformatf("rnd%0d_r%0d", it, r), rs, 12,
                   exp_row(r));
      step(2);
      check("rnd_idle", RW'(busy), RW'(0));
    end
    no_more("rnd", 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
